// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the two-port ALU arbiter
package alu_arb_pkg;

  localparam int ALU_W     = 16;
  localparam int ALU_SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef logic grant_t;

  // Turn a requester index into its one-hot handshake bit
  function automatic logic [1:0] grant_onehot(input grant_t g);
    return g ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - shared combinational ALU: add, sub, and, or, xor, not, shl1, shr1
module alu #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 3
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SEL_W-1:0] ALU_Sel,
  output logic [WIDTH-1:0] ALU_Out
);

  // Pure combinational operation select; result truncated to WIDTH
  always_comb begin
    ALU_Out = '0;
    case (ALU_Sel)
      SEL_W'(0): ALU_Out = A + B;
      SEL_W'(1): ALU_Out = A - B;
      SEL_W'(2): ALU_Out = A & B;
      SEL_W'(3): ALU_Out = A | B;
      SEL_W'(4): ALU_Out = A ^ B;
      SEL_W'(5): ALU_Out = ~A;
      SEL_W'(6): ALU_Out = A << 1;
      SEL_W'(7): ALU_Out = A >> 1;
      default:   ALU_Out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters; ALU_ARB_ROUND_ROBIN_EN selects round-robin
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int SEL_W = ALU_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [SEL_W-1:0] sel0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [SEL_W-1:0] sel1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [15:0]      ops_done
);

  arb_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  grant_t           grant_q, grant_d, last_grant_q, last_grant_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic [15:0]      ops_done_q, ops_done_d;
  logic [WIDTH-1:0] alu_out;
  grant_t           arb_pick;

  // Choose the winner among currently valid requests
  always_comb begin
    arb_pick = 1'b0;
    if (req_valid == 2'b11) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      arb_pick = ~last_grant_q;
`else
      arb_pick = 1'b0;
`endif
    end else if (req_valid[1]) begin
      arb_pick = 1'b1;
    end
  end

  // Accept only in IDLE, so requester inputs never bypass the operand registers
  always_comb begin
    req_ready = 2'b00;
    if (state_q == IDLE && (|req_valid)) begin
      req_ready = grant_onehot(arb_pick);
    end
  end

  // Next-state and datapath register updates for the IDLE/EXEC/RESP sequence
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sel_d        = sel_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    rsp_valid_d  = rsp_valid_q;
    ops_done_d   = ops_done_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          a_d          = arb_pick ? a1 : a0;
          b_d          = arb_pick ? b1 : b0;
          sel_d        = arb_pick ? sel1 : sel0;
          grant_d      = arb_pick;
          last_grant_d = arb_pick;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d    = alu_out;
        rsp_valid_d = grant_onehot(grant_q);
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          rsp_valid_d = 2'b00;
          ops_done_d  = ops_done_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Register all state; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
      rsp_valid_q  <= 2'b00;
      busy_q       <= 1'b0;
      ops_done_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sel_q        <= sel_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
      ops_done_q   <= ops_done_d;
    end
  end

  // While an operation is in flight the recorded last grant is its owner
  a_grant_tracks_last : assert property (@(posedge clk) disable iff (rst)
    (state_q != IDLE) |-> (grant_q == last_grant_q));

  alu #(
    .WIDTH(WIDTH),
    .SEL_W(SEL_W)
  ) u_alu (a_q, b_q, sel_q, alu_out);

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = result_q;
  assign busy      = busy_q;
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter against a behavioural model
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] a0, b0, a1, b1;
  logic [2:0]  sel0, sel1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [15:0] rsp_data;
  logic        busy;
  logic [15:0] ops_done;

  int          n_checks = 0;
  int          n_fail = 0;
  logic        lg;
  logic [15:0] exp_ops;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .a0(a0), .b0(b0), .sel0(sel0),
    .a1(a1), .b1(b1), .sel1(sel1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] golden(input logic [15:0] a, input logic [15:0] b, input logic [2:0] sel);
    case (sel)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return 16'hFFFF - a;
      3'd6: return a * 16'd2;
      default: return a / 16'd2;
    endcase
  endfunction

  // Full operation from an IDLE negedge through the response handshake
  task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] sel, input int stall, input logic other_valid);
    logic [1:0]  oh;
    logic [15:0] exp;
    oh  = (idx == 1) ? 2'b10 : 2'b01;
    exp = golden(a, b, sel);
    if (idx == 1) begin a1 = a; b1 = b; sel1 = sel; end
    else begin a0 = a; b0 = b; sel0 = sel; end
    req_valid = oh;
    rsp_ready = 2'b00;
    #1;
    n_checks++; if (req_ready !== oh) begin n_fail++; $display("FAIL op_accept got=%b exp=%b", req_ready, oh); end
    @(negedge clk);
    lg = (idx == 1);
    req_valid = other_valid ? ~oh : 2'b00;
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL op_exec_busy got=%b exp=1", busy); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL op_exec_req_ready got=%b exp=00", req_ready); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL op_exec_rsp_valid got=%b exp=00", rsp_valid); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== oh) begin n_fail++; $display("FAIL op_rsp_valid got=%b exp=%b", rsp_valid, oh); end
    n_checks++; if (rsp_data !== exp) begin n_fail++; $display("FAIL op_rsp_data sel=%0d got=%h exp=%h", sel, rsp_data, exp); end
    for (int s = 0; s < stall; s++) begin
      rsp_ready = ~oh;
      @(negedge clk);
      #1;
      n_checks++; if (rsp_valid !== oh) begin n_fail++; $display("FAIL stall_rsp_valid got=%b exp=%b", rsp_valid, oh); end
      n_checks++; if (rsp_data !== exp) begin n_fail++; $display("FAIL stall_rsp_data got=%h exp=%h", rsp_data, exp); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy got=%b exp=1", busy); end
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL stall_req_ready got=%b exp=00", req_ready); end
      n_checks++; if (ops_done !== exp_ops) begin n_fail++; $display("FAIL stall_ops_done got=%h exp=%h", ops_done, exp_ops); end
    end
    rsp_ready = oh;
    req_valid = 2'b00;
    @(negedge clk);
    rsp_ready = 2'b00;
    exp_ops = exp_ops + 16'd1;
    n_checks++; if (ops_done !== exp_ops) begin n_fail++; $display("FAIL op_ops_done got=%h exp=%h", ops_done, exp_ops); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL op_rsp_drop got=%b exp=00", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL op_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    a0 = '0; b0 = '0; sel0 = '0; a1 = '0; b1 = '0; sel1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0; lg = 1'b1; exp_ops = 16'd0;
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    n_checks++; if (rsp_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rsp_data got=%h exp=0000", rsp_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (ops_done !== 16'h0000) begin n_fail++; $display("FAIL reset_ops_done got=%h exp=0000", ops_done); end
  endtask

  task automatic test_single();
    run_op(0, 16'h0AB0, 16'h01AC, 3'h1, 0, 1'b0);
    n_checks++; if (ops_done !== 16'd1) begin n_fail++; $display("FAIL single_ops_done got=%h exp=0001", ops_done); end
    for (int i = 0; i < 4; i++)
      run_op(i % 2, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 0, 1'b0);
  endtask

  task automatic test_sweep();
    logic [15:0] a, b, start;
    a = 16'($urandom); b = 16'($urandom); start = exp_ops;
    for (int s = 0; s < 8; s++) run_op(1, a, b, 3'(s), 0, 1'b0);
    n_checks++; if (ops_done !== start + 16'd8) begin n_fail++; $display("FAIL sweep_ops_done got=%h exp=%h", ops_done, start + 16'd8); end
  endtask

  task automatic test_tie();
    logic [15:0] ta[2], tb[2];
    logic [2:0]  ts[2];
    logic [15:0] exp;
    logic [1:0]  oh;
    int          g;
    for (int r = 0; r < 2; r++) begin
      ta[r] = 16'($urandom); tb[r] = 16'($urandom); ts[r] = 3'($urandom_range(0, 7));
    end
    a0 = ta[0]; b0 = tb[0]; sel0 = ts[0]; a1 = ta[1]; b1 = tb[1]; sel1 = ts[1];
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      g = lg ? 0 : 1;
`else
      g = 0;
`endif
      oh = (g == 1) ? 2'b10 : 2'b01;
      exp = golden(ta[g], tb[g], ts[g]);
      #1;
      n_checks++; if (req_ready !== oh) begin n_fail++; $display("FAIL tie_grant%0d got=%b exp=%b", k, req_ready, oh); end
      @(negedge clk);
      lg = (g == 1);
      ta[g] = 16'($urandom); tb[g] = 16'($urandom); ts[g] = 3'($urandom_range(0, 7));
      if (g == 1) begin a1 = ta[1]; b1 = tb[1]; sel1 = ts[1]; end
      else begin a0 = ta[0]; b0 = tb[0]; sel0 = ts[0]; end
      @(negedge clk);
      n_checks++; if (rsp_valid !== oh) begin n_fail++; $display("FAIL tie_rsp_valid%0d got=%b exp=%b", k, rsp_valid, oh); end
      n_checks++; if (rsp_data !== exp) begin n_fail++; $display("FAIL tie_rsp_data%0d got=%h exp=%h", k, rsp_data, exp); end
      @(negedge clk);
      exp_ops = exp_ops + 16'd1;
    end
    req_valid = 2'b00; rsp_ready = 2'b00;
    n_checks++; if (ops_done !== exp_ops) begin n_fail++; $display("FAIL tie_ops_done got=%h exp=%h", ops_done, exp_ops); end
  endtask

  task automatic test_backpressure();
    run_op(0, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 5, 1'b1);
    run_op(1, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 5, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++)
      run_op(int'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
             3'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1'b0);
  endtask

  task automatic test_reset_mid(input int phase);
    a0 = 16'($urandom); b0 = 16'($urandom); sel0 = 3'($urandom_range(0, 7));
    req_valid = 2'b01; rsp_ready = 2'b00;
    @(negedge clk);
    req_valid = 2'b00;
    if (phase == 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; lg = 1'b1; exp_ops = 16'd0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid%0d_busy got=%b exp=0", phase, busy); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rstmid%0d_rsp_valid got=%b exp=00", phase, rsp_valid); end
    n_checks++; if (ops_done !== 16'd0) begin n_fail++; $display("FAIL rstmid%0d_ops_done got=%h exp=0000", phase, ops_done); end
    rsp_ready = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rstmid%0d_no_answer got=%b exp=00", phase, rsp_valid); end
      n_checks++; if (ops_done !== 16'd0) begin n_fail++; $display("FAIL rstmid%0d_no_count got=%h exp=0000", phase, ops_done); end
    end
    rsp_ready = 2'b00;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.ops_done_q = 16'hFFFE;
    @(negedge clk);
    release dut.ops_done_q;
    exp_ops = 16'hFFFE;
    run_op(0, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 0, 1'b0);
    n_checks++; if (ops_done !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff got=%h exp=ffff", ops_done); end
    run_op(1, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 0, 1'b0);
    n_checks++; if (ops_done !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got=%h exp=0000", ops_done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_tie();
    test_backpressure();
    test_back_to_back();
    test_reset_mid(1);
    test_reset_mid(2);
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
